// File: rtl/axis_tiled_stream_slice_if.sv
// Stream interfaces for axis_tiled_stream_slice.
//   axis_tiled_stream_slice_in_if  : tdata/tvalid/tready/tlast (upstream side, no tuser)
//   axis_tiled_stream_slice_out_if : tdata/tvalid/tready/tlast/tuser (downstream side)
// master drives tdata/tvalid/tlast(/tuser) and samples tready; slave is the mirror.

interface axis_tiled_stream_slice_in_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface axis_tiled_stream_slice_out_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_tiled_stream_slice.sv
// axis_tiled_stream_slice
// AXI-Stream stage for blocked tensors: per-lane sign/zero extension with optional
// ReLU, block (tlast) and tensor (tuser) marker generation, upstream tlast checking,
// and a two-entry skid buffer (output register + skid register) at full throughput.
//
// Ports:
//   ap_clk, ap_rst_n  : clock, asynchronous active-low reset
//   s_axis_input0     : input stream, SDIM lanes of INPUT0_WIDTH bits (tlast checked only)
//   m_axis_output0    : output stream, SDIM lanes of OUTPUT0_WIDTH bits,
//                       tlast = last beat of block, tuser = last beat of tensor
//   tensor_done       : one-cycle pulse after the final beat of a tensor is accepted
//   tlast_err         : sticky, upstream tlast disagreed with the computed block end

module axis_tiled_stream_slice #(
    parameter int INPUT0_WIDTH  = 8,
    parameter int OUTPUT0_WIDTH = 8,
    parameter int SDIM          = 4,
    parameter int BDIM          = 16,
    parameter int NUM_BLOCKS    = 4,
    parameter int SIGNED        = 1,
    parameter int MODE          = 0
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    axis_tiled_stream_slice_in_if.slave   s_axis_input0,
    axis_tiled_stream_slice_out_if.master m_axis_output0,
    output logic                          tensor_done,
    output logic                          tlast_err
);

    localparam int BPB    = BDIM / SDIM;
    localparam int BEAT_W = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int OUT_W  = SDIM * OUTPUT0_WIDTH;
    localparam int EXT_W  = OUTPUT0_WIDTH - INPUT0_WIDTH;

    logic [OUT_W-1:0]  proc_data;

    logic              ready_q, ready_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              out_user_q, out_user_d;
    logic              skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0]  skid_data_q, skid_data_d;
    logic              skid_last_q, skid_last_d;
    logic              skid_user_q, skid_user_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic              tlast_err_q, tlast_err_d;
    logic              tensor_done_q, tensor_done_d;

    logic              in_fire, out_fire;
    logic              comp_last, comp_user;

    // Per-lane extension and optional ReLU.
    for (genvar i = 0; i < SDIM; i++) begin : g_lane
        logic [INPUT0_WIDTH-1:0]  lane_in;
        logic [OUTPUT0_WIDTH-1:0] lane_ext;
        logic                     sign_bit;

        assign lane_in  = s_axis_input0.tdata[i*INPUT0_WIDTH +: INPUT0_WIDTH];
        assign sign_bit = (SIGNED != 0) && lane_in[INPUT0_WIDTH-1];

        if (EXT_W > 0) begin : g_ext
            assign lane_ext = {{EXT_W{sign_bit}}, lane_in};
        end else begin : g_noext
            assign lane_ext = lane_in;
        end

        assign proc_data[i*OUTPUT0_WIDTH +: OUTPUT0_WIDTH] =
            ((MODE == 1) && sign_bit) ? '0 : lane_ext;
    end

    assign in_fire   = s_axis_input0.tvalid && ready_q;
    assign out_fire  = out_valid_q && m_axis_output0.tready;
    assign comp_last = (beat_cnt_q == BEAT_W'(BPB - 1));
    assign comp_user = comp_last && (blk_cnt_q == BLK_W'(NUM_BLOCKS - 1));

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_user_d    = out_user_q;
        skid_valid_d  = skid_valid_q;
        skid_data_d   = skid_data_q;
        skid_last_d   = skid_last_q;
        skid_user_d   = skid_user_q;
        beat_cnt_d    = beat_cnt_q;
        blk_cnt_d     = blk_cnt_q;
        tlast_err_d   = tlast_err_q;
        tensor_done_d = out_fire && out_user_q;

        if (in_fire) begin
            if (comp_last) begin
                beat_cnt_d = '0;
                blk_cnt_d  = (blk_cnt_q == BLK_W'(NUM_BLOCKS - 1)) ? '0 : blk_cnt_q + BLK_W'(1);
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
            if (s_axis_input0.tlast != comp_last) begin
                tlast_err_d = 1'b1;
            end
        end

        // ready_q == !skid_valid_q, so in_fire never coincides with a full skid.
        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                out_user_d   = skid_user_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = proc_data;
                out_last_d  = comp_last;
                out_user_d  = comp_user;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = proc_data;
            skid_last_d  = comp_last;
            skid_user_d  = comp_user;
        end

        ready_d = !skid_valid_d;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ready_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_user_q    <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            skid_last_q   <= 1'b0;
            skid_user_q   <= 1'b0;
            beat_cnt_q    <= '0;
            blk_cnt_q     <= '0;
            tlast_err_q   <= 1'b0;
            tensor_done_q <= 1'b0;
        end else begin
            ready_q       <= ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_user_q    <= out_user_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            skid_last_q   <= skid_last_d;
            skid_user_q   <= skid_user_d;
            beat_cnt_q    <= beat_cnt_d;
            blk_cnt_q     <= blk_cnt_d;
            tlast_err_q   <= tlast_err_d;
            tensor_done_q <= tensor_done_d;
        end
    end

    assign s_axis_input0.tready  = ready_q;
    assign m_axis_output0.tvalid = out_valid_q;
    assign m_axis_output0.tdata  = out_data_q;
    assign m_axis_output0.tlast  = out_last_q;
    assign m_axis_output0.tuser  = out_user_q;
    assign tensor_done           = tensor_done_q;
    assign tlast_err             = tlast_err_q;

endmodule
